// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and helpers for the fetch-redirect front end.
//   fetch_state_t : PC-generator FSM states (BOOT, RUN, FLUSH)
//   FLUSH_CNT_W   : width of the flush countdown counter
//   align_mask()  : mask that clears the intra-bundle offset bits of a PC
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam int FLUSH_CNT_W = 4;

  // Bundle size is a power of two, so (size - 1) covers exactly the offset bits.
  function automatic logic [31:0] align_mask(input int bundle_bytes);
    return ~(32'(bundle_bytes) - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_redirect_stats.sv
// ---------------------------------------------------------------------------
// fetch_redirect_stats
// Saturating event counters for the fetch front end. Only instantiated when
// FETCH_REDIRECT_STATS_EN is defined.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   i_redirect          : an accepted redirect this cycle
//   i_stall_run         : a RUN-state cycle with stall asserted
//   o_redirect_count    : number of accepted redirects (saturating)
//   o_stall_count       : number of stalled RUN cycles (saturating)
// ---------------------------------------------------------------------------
module fetch_redirect_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_redirect,
  input  logic        i_stall_run,
  output logic [31:0] o_redirect_count,
  output logic [31:0] o_stall_count
);

  logic [31:0] r_redirect_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_count <= '0;
      r_stall_count    <= '0;
    end else begin
      if (i_redirect && (r_redirect_count != 32'hFFFF_FFFF))
        r_redirect_count <= r_redirect_count + 32'd1;
      if (i_stall_run && (r_stall_count != 32'hFFFF_FFFF))
        r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign o_redirect_count = r_redirect_count;
  assign o_stall_count    = r_stall_count;

endmodule

// File: rtl/fetch_redirect.sv
// ---------------------------------------------------------------------------
// fetch_redirect
// Program-counter generator and fetch-redirect controller. Issues sequential
// bundle addresses over a valid/ready handshake, redirects on taken branch
// resolutions, and drives a timed flush during which fetch is suppressed.
// All outputs are registered.
//
// Parameters:
//   RESET_PC     : first fetch address after reset
//   BUNDLE_BYTES : sequential increment (power of two, >= 4)
//   FLUSH_CYCLES : cycles flush stays high per redirect (1..15)
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   br_valid/branch_taken : branch resolution present / taken
//   new_pc                : redirect target
//   stall                 : hazard stall, hold the PC
//   fetch_ready           : instruction memory accepts fetch_pc
//   fetch_valid, fetch_pc : fetch request
//   flush                 : kill younger in-flight instructions
//   misalign_err          : one-cycle pulse on a misaligned taken target
// Optional build macro FETCH_REDIRECT_STATS_EN adds redirect_count and
// stall_count (saturating 32-bit counters).
// ---------------------------------------------------------------------------
module fetch_redirect
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          BUNDLE_BYTES = 16,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_valid,
  input  logic        branch_taken,
  input  logic [31:0] new_pc,
  input  logic        stall,
  input  logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic        flush,
  output logic        misalign_err
`ifdef FETCH_REDIRECT_STATS_EN
  ,
  output logic [31:0] redirect_count,
  output logic [31:0] stall_count
`endif
);

  localparam logic [31:0] PC_INC  = 32'(BUNDLE_BYTES);
  localparam logic [31:0] PC_MASK = align_mask(BUNDLE_BYTES);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

  fetch_state_t           r_state;
  fetch_state_t           w_next_state;
  logic [31:0]            r_pc;
  logic [31:0]            w_pc_nxt;
  logic                   r_fetch_valid;
  logic                   w_valid_nxt;
  logic                   r_flush;
  logic                   w_flush_nxt;
  logic                   r_misalign;
  logic                   w_misalign_nxt;
  logic [FLUSH_CNT_W-1:0] r_cnt;
  logic [FLUSH_CNT_W-1:0] w_cnt_nxt;

  logic w_redirect;
  logic w_advance;
  logic w_flush_done;

  // Redirects are ignored while booting; otherwise they override everything.
  assign w_redirect   = br_valid && branch_taken && (r_state != BOOT);
  // Stall takes priority over the sequential advance.
  assign w_advance    = (r_state == RUN) && r_fetch_valid && fetch_ready && !stall;
  assign w_flush_done = (r_cnt <= FLUSH_CNT_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BOOT;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      BOOT:    w_next_state = RUN;
      RUN:     w_next_state = w_redirect ? FLUSH : RUN;
      FLUSH:   w_next_state = w_redirect ? FLUSH : (w_flush_done ? RUN : FLUSH);
      default: w_next_state = BOOT;
    endcase
  end

  // Output logic: next values of the registered outputs and flush counter
  always_comb begin
    w_pc_nxt       = r_pc;
    w_valid_nxt    = 1'b0;
    w_flush_nxt    = 1'b0;
    w_misalign_nxt = 1'b0;
    w_cnt_nxt      = r_cnt;
    if (w_redirect) begin
      // A redirect in FLUSH retargets and restarts the countdown.
      w_pc_nxt       = new_pc & PC_MASK;
      w_misalign_nxt = |(new_pc & ~PC_MASK);
      w_cnt_nxt      = FLUSH_LOAD;
      w_flush_nxt    = 1'b1;
    end else begin
      case (r_state)
        BOOT: begin
          w_valid_nxt = !stall;
          w_cnt_nxt   = '0;
        end
        RUN: begin
          w_valid_nxt = !stall;
          if (w_advance) w_pc_nxt = r_pc + PC_INC;
        end
        FLUSH: begin
          // Stall is not consulted here; fetch resumes as soon as flush ends.
          w_cnt_nxt   = w_flush_done ? '0 : r_cnt - FLUSH_CNT_W'(1);
          w_flush_nxt = !w_flush_done;
          w_valid_nxt = w_flush_done;
        end
        default: begin
          w_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_fetch_valid <= 1'b0;
      r_flush       <= 1'b0;
      r_misalign    <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_fetch_valid <= w_valid_nxt;
      r_flush       <= w_flush_nxt;
      r_misalign    <= w_misalign_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  assign fetch_pc     = r_pc;
  assign fetch_valid  = r_fetch_valid;
  assign flush        = r_flush;
  assign misalign_err = r_misalign;

`ifdef FETCH_REDIRECT_STATS_EN
  logic w_stall_run;
  assign w_stall_run = (r_state == RUN) && stall;

  fetch_redirect_stats u_stats (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_redirect       (w_redirect),
    .i_stall_run      (w_stall_run),
    .o_redirect_count (redirect_count),
    .o_stall_count    (stall_count)
  );
`endif

endmodule

// File: doc/fetch_redirect.md
# fetch_redirect

Program-counter generator and fetch-redirect controller for the VLIW front end. Issues sequential bundle fetch addresses to instruction memory over a valid/ready handshake, and consumes branch resolutions (`branch_taken`/`new_pc`) from the branch execute stage. On a taken resolution it redirects the PC, drives a timed pipeline flush, and suppresses fetch until the flush completes.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `BUNDLE_BYTES`, default 16: sequential PC increment. Must be a power of two, at least 4.
- `FLUSH_CYCLES`, default 2: cycles `flush` stays asserted per redirect. Range 1–15.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `br_valid`  in  1  a branch resolution is present this cycle.
- `branch_taken`  in  1  the resolution is taken (from branch execute).
- `new_pc`  in  32  redirect target (from branch execute).
- `stall`  in  1  hazard stall; hold the current PC.
- `fetch_ready`  in  1  instruction memory accepts the address.
- `fetch_valid`  out  1  `fetch_pc` is a valid request.
- `fetch_pc`  out  32  bundle fetch address.
- `flush`  out  1  kill younger in-flight instructions.
- `misalign_err`  out  1  one-cycle pulse when a taken target is misaligned.

## Operation
- States: `BOOT`, `RUN`, `FLUSH`.
- **BOOT**
  - Entered on reset.
  - `fetch_pc`=`RESET_PC`, `fetch_valid`=0.
  - Moves to RUN unconditionally on the next clock.
- **RUN**
  - `fetch_valid`=1 and `!stall`.
  - When `fetch_valid && fetch_ready`, `fetch_pc` += `BUNDLE_BYTES`.
  - Arithmetic is modulo 2^32: 32'hFFFF_FFF0 + 16 wraps to 0.
  - When `stall`=1, `fetch_valid` is 0 and the PC holds.
- **Redirect**, when `br_valid && branch_taken` in any state other than BOOT:
  - `fetch_pc` <= `new_pc` with bits [log2(BUNDLE_BYTES)-1:0] cleared.
  - `misalign_err` pulses if those bits were non-zero.
  - Load the flush counter with `FLUSH_CYCLES`; enter FLUSH.
- `br_valid` with `branch_taken`=0 is ignored.
- `br_valid` in BOOT is ignored.
- **FLUSH**
  - `flush`=1, `fetch_valid`=0.
  - The counter decrements each cycle; at 1 → RUN.
  - `stall` is ignored in FLUSH.
- **Priority:** redirect > stall > sequential advance.
  - A redirect in the same cycle as a handshake discards the increment.
- **Redirect during FLUSH:** retarget to the newest `new_pc` and reload the counter with `FLUSH_CYCLES`; the last redirect wins.
- **`fetch_ready` low while `fetch_valid`:** `fetch_pc` must hold stable until accepted or redirected.

## Timing
- **Reset values:** `fetch_pc`=`RESET_PC`, `fetch_valid`=0, `flush`=0, `misalign_err`=0, state=BOOT, counter=0.
- **Reset mid-flush:** aborts immediately (asynchronous); all outputs go to reset values.
- All outputs are registered; there are no combinational input-to-output paths.
- **Redirect latency, `br_valid` sampled at edge N:**
  - Edges N+1 … N+FLUSH_CYCLES: `flush`=1, `fetch_pc`=target.
  - Edge N+FLUSH_CYCLES+1: `fetch_valid`=1.
- `misalign_err` is high for exactly the cycle after the offending redirect.
- **Minimum reset-to-first-fetch:** `fetch_valid` rises one cycle after `rst_n` deasserts.

## Configuration
- **`FETCH_REDIRECT_STATS_EN` defined:**
  - Adds output `redirect_count` (32 bits), which increments on every accepted redirect, including retargets during FLUSH.
  - Adds output `stall_count` (32 bits), which increments each RUN cycle with `stall`=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- **Undefined:** neither port exists and no counter logic is synthesized.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_state_t` enum (BOOT, RUN, FLUSH).
  - Localparam for the flush counter width (4).
  - Alignment-mask helper function.
- One sub-module, `fetch_redirect_stats`: the two saturating counters, instantiated only under `FETCH_REDIRECT_STATS_EN`.
- The PC register, FSM and flush counter stay in `fetch_redirect`.

## Test plan
- **Reset:** release `rst_n` with `fetch_ready`=1 → cycle 1 `fetch_valid`=1, `fetch_pc`=0, then 0x10, 0x20 on successive cycles.
- **Backpressure:** `fetch_ready`=0 for 3 cycles at `fetch_pc`=0x20 → `fetch_pc` holds at 0x20 with `fetch_valid`=1; advances to 0x30 after `fetch_ready`=1.
- **Taken redirect:** at `fetch_pc`=0x40, `br_valid`=1, `branch_taken`=1, `new_pc`=0x1000 → `flush`=1 for 2 cycles, `fetch_valid`=0; then `fetch_valid`=1 at 0x1000, 0x1010 next.
- **Not-taken, misaligned, wrap:**
  - `br_valid`=1, `branch_taken`=0 → no flush, PC keeps incrementing.
  - Taken `new_pc`=0x1006 → target 0x1000, `misalign_err` pulses once.
  - `fetch_pc`=0xFFFF_FFF0 accepted → next 0x0.
- **Back-to-back redirects:** taken to 0x200, then taken to 0x300 one cycle later (in FLUSH) → `flush` extends to 3 cycles total, and fetch resumes at 0x300.
- **Stall vs redirect, reset mid-flush:**
  - `stall`=1 with a same-cycle taken redirect → redirect wins.
  - `rst_n` low during FLUSH → outputs reset immediately.
  - With `FETCH_REDIRECT_STATS_EN`, `redirect_count` reads 1 after a single redirect.
